// File: rtl/hash_msg_feeder_pkg.sv
// hash_pkg: shared types and constants for the hash message feeder.
//   MSG_W      - byte width of the host stream and core interface
//   LEN_W_DEF  - default width of the message-length counter
//   ENTRY_W    - packed width of one FIFO entry
//   feeder_state_t - feeder FSM states
//   fifo_entry_t   - {data, last, empty} as stored in the FIFO
package hash_pkg;

  localparam int MSG_W     = 8;
  localparam int LEN_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FILL        = 2'd1,
    DRAIN       = 2'd2,
    WAIT_DIGEST = 2'd3
  } feeder_state_t;

  typedef struct packed {
    logic [MSG_W-1:0] data;
    logic             last;
    logic             empty;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/hash_msg_feeder_byte_fifo.sv
// hash_byte_fifo: synchronous FIFO of fifo_entry_t words.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (flushes pointers)
//   i_push, i_entry - write request and data (ignored when full)
//   i_pop           - read request (ignored when empty)
//   o_head          - entry at the head of the FIFO, read from registered storage
//   o_full, o_empty - occupancy flags
module hash_byte_fifo
  import hash_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_entry,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic               o_full,
  output logic               o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic               w_push;
  logic               w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder: buffers a host byte stream and hands it to the hash core
// one byte per handshake, tracking the message length in bytes.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   in_valid/in_ready           - host handshake
//   in_data, in_last, in_empty  - host byte, final flag, zero-length flag
//   m_valid/m_ready             - core handshake
//   message, m_last, m_empty    - byte to core, final flag, no-byte flag
//   counter                     - message length in bytes (mod 2^LEN_W)
//   hash_done                   - core pulse: digest complete
//   busy                        - a message is accepted and not yet digested
//
// state       | meaning
// IDLE        | no message, FIFO empty
// FILL        | accepting beats of a message
// DRAIN       | last beat taken, FIFO emptying to the core
// WAIT_DIGEST | whole message handed over, waiting for hash_done
module hash_msg_feeder
  import hash_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] in_data,
  input  logic             in_last,
  input  logic             in_empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [MSG_W-1:0] message,
  output logic             m_last,
  output logic             m_empty,
  output logic [LEN_W-1:0] counter,
  input  logic             hash_done,
  output logic             busy
);

  feeder_state_t      r_state;
  feeder_state_t      w_state_nxt;
  logic [LEN_W-1:0]   r_counter;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head_bits;
  fifo_entry_t        w_head;

  assign in_ready = !rst && !w_full && ((r_state == IDLE) || (r_state == FILL));
  // An empty beat without last is accepted on the handshake but never stored.
  assign w_push   = in_valid && in_ready && !(in_empty && !in_last);
  // rst gates m_valid so the core never sees a transfer during reset.
  assign m_valid  = !w_empty && !rst;
  assign w_pop    = m_valid && m_ready;
  assign w_head   = w_head_bits;

  assign message  = (m_valid && !w_head.empty) ? w_head.data : '0;
  assign m_last   = m_valid && w_head.last;
  assign m_empty  = m_valid && w_head.empty;
  assign counter  = r_counter;
  assign busy     = (r_state != IDLE);

  hash_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry ({in_data, in_last, in_empty}),
    .i_pop   (w_pop),
    .o_head  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:        if (w_push) w_state_nxt = in_last ? DRAIN : FILL;
      FILL:        if (w_push && in_last) w_state_nxt = DRAIN;
      DRAIN:       if (w_pop && w_head.last) w_state_nxt = WAIT_DIGEST;
      WAIT_DIGEST: if (hash_done) w_state_nxt = IDLE;
      default:     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // The first push of a message restarts the count; later pushes add one
  // per real byte. No pushes happen after the last beat, so the value holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_counter <= '0;
    end else if (w_push) begin
      if (r_state == IDLE)  r_counter <= LEN_W'(!in_empty);
      else if (!in_empty)   r_counter <= r_counter + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_hash_msg_feeder.sv
module tb_hash_msg_feeder;

  localparam int TB_DEPTH = 4;
  localparam int TB_LEN_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_data;
  logic                in_last;
  logic                in_empty;
  logic                m_valid;
  logic                m_ready;
  logic [7:0]          message;
  logic                m_last;
  logic                m_empty;
  logic [TB_LEN_W-1:0] counter;
  logic                hash_done;
  logic                busy;

  typedef struct {
    logic [7:0]          data;
    logic                last;
    logic                empty;
    logic [TB_LEN_W-1:0] cnt;
  } exp_t;

  exp_t                sb_q[$];
  int                  n_checks = 0;
  int                  n_fail   = 0;
  logic [TB_LEN_W-1:0] tb_len   = '0;
  logic                tb_first = 1'b1;
  logic                stall_v  = 1'b0;
  logic [10:0]         stall_snap;

  always #5 clk = ~clk;

  hash_msg_feeder #(
    .DEPTH (TB_DEPTH),
    .LEN_W (TB_LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .message   (message),
    .m_last    (m_last),
    .m_empty   (m_empty),
    .counter   (counter),
    .hash_done (hash_done),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, pops on each transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_v = 1'b0;
      end else begin
        if (stall_v)
          chk("stall_hold", {m_valid, message, m_last, m_empty}, stall_snap);
        if (m_valid && m_ready) begin
          stall_v = 1'b0;
          if (sb_q.size() == 0) begin
            chk("unexpected_xfer", {m_valid, message}, 64'h0);
          end else begin
            e = sb_q.pop_front();
            chk("message", message, e.data);
            chk("m_last", m_last, e.last);
            chk("m_empty", m_empty, e.empty);
            if (e.last) chk("counter_at_last", counter, e.cnt);
          end
        end else if (m_valid) begin
          stall_v    = 1'b1;
          stall_snap = {m_valid, message, m_last, m_empty};
        end else begin
          stall_v = 1'b0;
        end
      end
    end
  end

  // Drives one beat from posedge+1 and returns at posedge+1 after acceptance.
  task automatic send(input logic [7:0] d, input logic l, input logic e);
    exp_t x;
    int   n = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_empty = e;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (!(e && !l)) begin
        if (tb_first)  tb_len = e ? 4'd0 : 4'd1;
        else if (!e)   tb_len = tb_len + 4'd1;
        tb_first = l;
        x.data = e ? 8'h00 : d;
        x.last = l; x.empty = e; x.cnt = tb_len;
        sb_q.push_back(x);
      end
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || m_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || m_valid) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_done();
    hash_done = 1'b1;
    @(posedge clk); #1;
    hash_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_empty = 1'b0;
    m_ready = 1'b1; hash_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_message", message, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_empty", m_empty, 0);
    chk("rst_counter", counter, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // 1: "abc"
    send(8'h61, 0, 0); send(8'h62, 0, 0); send(8'h63, 1, 0);
    wait_drain();
    chk("t1_counter", counter, 3);
    chk("t1_in_ready_wait", in_ready, 0);
    chk("t1_busy_wait", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_in_ready_still", in_ready, 0);
    pulse_done();
    chk("t1_in_ready_after", in_ready, 1);
    chk("t1_busy_after", busy, 0);

    // 2: back-pressure with a full FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 0, 0);
    @(negedge clk);
    chk("t2_full_in_ready", in_ready, 0);
    chk("t2_m_valid_stall", m_valid, 1);
    chk("t2_head", message, 8'h10);
    @(posedge clk); #1;
    fork
      send(8'h14, 1, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("t2_full_pop_in_ready", in_ready, 0);
      end
    join
    wait_drain();
    chk("t2_counter", counter, 5);
    pulse_done();

    // 3: zero-length message
    send(8'hAA, 1, 1);
    wait_drain();
    chk("t3_counter", counter, 0);
    pulse_done();

    // 4: reset mid-message
    m_ready = 1'b0;
    send(8'h21, 0, 0); send(8'h22, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_in_ready", in_ready, 0);
    sb_q.delete(); tb_first = 1'b1; tb_len = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_m_valid", m_valid, 0);
    chk("t4_counter", counter, 0);
    chk("t4_busy", busy, 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(8'h55, 1, 0);
    wait_drain();
    chk("t4_counter_fresh", counter, 1);
    pulse_done();

    // 5: stray hash_done, then back-to-back messages
    pulse_done();
    chk("t5_stray_busy", busy, 0);
    chk("t5_stray_in_ready", in_ready, 1);
    chk("t5_stray_counter", counter, 1);
    send(8'h01, 1, 0);
    wait_drain();
    chk("t5_counter1", counter, 1);
    in_valid = 1'b1; in_data = 8'h02; in_last = 1'b0; in_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_blocked_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulse_done();
    send(8'h02, 0, 0); send(8'h03, 1, 0);
    wait_drain();
    chk("t5_counter2", counter, 2);
    pulse_done();

    // 6: 17 bytes wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) send(8'h40 + 8'(i), (i == 16), 0);
    wait_drain();
    chk("t6_counter_wrap", counter, 1);
    pulse_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hash_msg_feeder.md
Name: hash_msg_feeder

Overview:
Upstream stage of full_hash_des_box. Accepts a host byte stream through a valid/ready handshake and buffers it in a small FIFO. Presents one byte per handshake to the hash core and flags the final byte. Tracks the message length in bytes and supplies it as the 64-bit counter the core consumes. Once a message has been handed over, it blocks new input until the core reports that the digest is complete.

Parameters:
DEPTH, 4, FIFO depth in entries; power of two, at least 2.
LEN_W, 64, length-counter width; must be 64 when connected to the core, may be reduced in benches.

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  host beat valid
in_ready  output  1  feeder can accept a beat
in_data  input  8  message byte
in_last  input  1  beat is final of message
in_empty  input  1  beat carries no byte; legal only with in_last (zero-length message)
m_valid  output  1  byte presented to core
m_ready  input  1  core accepts byte
message  output  8  byte to core
m_last  output  1  presented byte is final
m_empty  output  1  final transfer carries no byte
counter  output  LEN_W  message length in bytes
hash_done  input  1  one-cycle pulse from core: digest ready
busy  output  1  message in flight (accepted, not yet digested)

Behaviour:
- Reset values: m_valid=0, message=0, m_last=0, m_empty=0, counter=0, busy=0. FIFO is flushed and state goes to IDLE. in_ready is forced to 0 while rst=1.
- Reset mid-operation discards all buffered and partial message data. No transfer occurs in the reset cycle.
- States:
  - IDLE: FIFO empty, no message. The first accepted beat goes to FILL (or to DRAIN if in_last).
  - FILL: accepts beats. Accepting an in_last beat goes to DRAIN.
  - DRAIN: no input; the FIFO empties to the core. The m_last transfer goes to WAIT_DIGEST.
  - WAIT_DIGEST: hash_done goes to IDLE.
- in_ready = !rst && !fifo_full && state in {IDLE, FILL}. It is combinational and must not depend on in_valid.
- Push occurs when in_valid && in_ready. The FIFO entry is {in_data, in_last, in_empty}.
- counter increments by 1 on every push with in_empty=0. It wraps modulo 2^LEN_W.
- counter clears to 0 on the cycle of the first push of a new message (value after that push is 1, or 0 for an empty beat).
- counter is held stable from the last push until hash_done.
- Core side: m_valid = fifo non-empty. message, m_last and m_empty come from the FIFO head; m_empty=1 forces message to 0.
- A pop occurs when m_valid && m_ready.
- m_valid, message, m_last and m_empty hold stable while m_valid=1 and m_ready=0.
- Latency: a byte pushed in cycle N is presented on m_valid in cycle N+1 at the earliest. There is no combinational in-to-out path.
- When full, in_ready=0 even if a pop occurs in the same cycle. A simultaneous push and pop on a non-full, non-empty FIFO leaves the occupancy unchanged.
- busy = state in {FILL, DRAIN, WAIT_DIGEST}.
- hash_done outside WAIT_DIGEST is ignored.
- Beats with in_empty=1 and in_last=0 are a protocol violation. They are dropped and not counted.
- Byte order is preserved exactly; no reordering and no padding are performed here.

Decomposition:
- Package hash_pkg holds:
  - constants MSG_W=8 and LEN_W_DEF=64;
  - typedef feeder_state_t {IDLE, FILL, DRAIN, WAIT_DIGEST};
  - packed struct fifo_entry_t {data[7:0], last, empty}.
- Sub-module hash_byte_fifo: synchronous FIFO parameterised by DEPTH, with registered storage, full/empty flags and a pointer wrap on power-of-two depth.
- Top level holds the FSM, the length counter and the handshake glue.

Test Plan:
1. Reset, then send 0x61, 0x62, 0x63 (last on 0x63) with m_ready=1 -> three transfers in order; m_last on 0x63; counter=3; in_ready=0 until a hash_done pulse, then 1.
2. m_ready=0, push 0x10..0x13 (DEPTH=4) -> in_ready falls after the 4th push and 0x14 is held. Release m_ready -> 0x10..0x14 delivered in order, m_valid payload stable during the stall.
3. in_valid with in_last=1 and in_empty=1 -> exactly one transfer with m_last=1, m_empty=1, message=0, counter=0.
4. Assert rst after 2 of 5 bytes are accepted -> next cycle m_valid=0, counter=0, busy=0. A fresh 1-byte message then yields counter=1.
5. hash_done pulse in IDLE -> no effect. Back-to-back messages of length 1 and 2, each followed by hash_done -> counter reads 1, then 2; the second message is not accepted before the first hash_done.
6. LEN_W=4, a 17-byte message -> counter=1 at m_last (wrap-around).
